// File: rtl/move_sequencer_pkg.sv
// Shared state encoding and helpers for the move-instruction sequencer.
package move_sequencer_pkg;

  typedef enum logic [2:0] {
    MS_IDLE = 3'd0,
    MS_F_SD = 3'd1,
    MS_F_SA = 3'd2,
    MS_F_TD = 3'd3,
    MS_F_TA = 3'd4,
    MS_RD   = 3'd5,
    MS_WR   = 3'd6
  } ms_state_e;

  function automatic logic is_fetch_state(input ms_state_e s);
    return (s == MS_F_SD) || (s == MS_F_SA) || (s == MS_F_TD) || (s == MS_F_TA);
  endfunction

  function automatic logic is_dev_state(input ms_state_e s);
    return (s == MS_RD) || (s == MS_WR);
  endfunction

endpackage

// File: rtl/move_sequencer_ack_timer.sv
// Wait-cycle counter for a pending request; expires on the TIMEOUT-th unacknowledged cycle.
module ack_timer #(
  parameter int TW_WIDTH = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  logic [TW_WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + TW_WIDTH'(1);
    end
  end

  // Combinational so the FSM leaves on the same edge that would complete the last waiting cycle.
  assign expire_o = enable_i && (count_q == TW_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/move_sequencer.sv
// Move-instruction sequencer: fetches four words, then performs a device read followed by a device write.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    TIMEOUT    = 255,
  parameter int                    TW_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] HALT_ID    = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_pc_init,
  output logic                  o_busy,
  output logic                  o_ir_req,
  output logic [ADDR_WIDTH-1:0] o_ir_addr,
  input  logic                  i_ir_ack,
  input  logic [DATA_WIDTH-1:0] i_ir,
  output logic                  o_dev_req,
  output logic                  o_dev_we,
  output logic [DATA_WIDTH-1:0] o_dev_id,
  output logic [DATA_WIDTH-1:0] o_dev_addr,
  output logic [DATA_WIDTH-1:0] o_dev_wdata,
  input  logic                  i_dev_ack,
  input  logic [DATA_WIDTH-1:0] i_dev_rdata,
  output logic                  o_done,
  output logic                  o_err
);

  ms_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] sd_q, sd_d, sa_q, sa_d, td_q, td_d, ta_q, ta_d, data_q, data_d;
  logic                  done_q, done_d, err_q, err_d;
  logic                  advance, expire;

  ack_timer #(
    .TW_WIDTH(TW_WIDTH),
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_q == MS_IDLE || advance),
    .enable_i(state_q != MS_IDLE && !advance),
    .expire_o(expire)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sd_d    = sd_q;
    sa_d    = sa_q;
    td_d    = td_q;
    ta_d    = ta_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    advance = 1'b0;
    if (is_fetch_state(state_q) && i_ir_ack) begin
      advance = 1'b1;
      pc_d    = pc_q + ADDR_WIDTH'(1);
    end else if (is_dev_state(state_q) && i_dev_ack) begin
      advance = 1'b1;
    end
    unique case (state_q)
      MS_IDLE: begin
        if (i_start) begin
          state_d = MS_F_SD;
          pc_d    = i_pc_init;
          err_d   = 1'b0;
        end
      end
      MS_F_SD: begin
        if (i_ir_ack) begin
          sd_d = i_ir;
          if (i_ir == HALT_ID) begin
            state_d = MS_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = MS_F_SA;
          end
        end
      end
      MS_F_SA: if (i_ir_ack) begin sa_d = i_ir; state_d = MS_F_TD; end
      MS_F_TD: if (i_ir_ack) begin td_d = i_ir; state_d = MS_F_TA; end
      MS_F_TA: if (i_ir_ack) begin ta_d = i_ir; state_d = MS_RD; end
      MS_RD:   if (i_dev_ack) begin data_d = i_dev_rdata; state_d = MS_WR; end
      MS_WR:   if (i_dev_ack) state_d = MS_F_SD;
      default: state_d = MS_IDLE;
    endcase
    // Expiry only fires on a cycle without the matching ack, so it never competes with a capture.
    if (expire) begin
      state_d = MS_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MS_IDLE;
      pc_q    <= '0;
      sd_q    <= '0;
      sa_q    <= '0;
      td_q    <= '0;
      ta_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sd_q    <= sd_d;
      sa_q    <= sa_d;
      td_q    <= td_d;
      ta_q    <= ta_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Requests decode from state alone so they fall together with the asynchronous reset.
  always_comb begin
    o_busy      = (state_q != MS_IDLE);
    o_ir_req    = is_fetch_state(state_q);
    o_ir_addr   = pc_q;
    o_dev_req   = is_dev_state(state_q);
    o_dev_we    = (state_q == MS_WR);
    o_dev_id    = '0;
    o_dev_addr  = '0;
    o_dev_wdata = '0;
    if (state_q == MS_RD) begin
      o_dev_id   = sd_q;
      o_dev_addr = sa_q;
    end else if (state_q == MS_WR) begin
      o_dev_id    = td_q;
      o_dev_addr  = ta_q;
      o_dev_wdata = data_q;
    end
    o_done = done_q;
    o_err  = err_q;
  end

endmodule
